// File: rtl/iso_rx_deframer_pkg.sv
// Shared constants and types for the DisplayPort sink-side deframer.
// Symbol codes, lane_count encodings, FSM states and the header length.
package iso_rx_pkg;

  localparam logic [7:0] K_BS = 8'hBC;
  localparam logic [7:0] K_SR = 8'h1C;
  localparam logic [7:0] K_BE = 8'hFB;
  localparam logic [7:0] K_FS = 8'hFE;
  localparam logic [7:0] K_FE = 8'hF7;
  localparam logic [7:0] K_SS = 8'h5C;
  localparam logic [7:0] K_SE = 8'hFD;

  localparam logic [1:0] LC_1   = 2'b00;
  localparam logic [1:0] LC_2   = 2'b01;
  localparam logic [1:0] LC_ILL = 2'b10;
  localparam logic [1:0] LC_4   = 2'b11;

  // VB-ID, Mvid[7:0], Maud[7:0]
  localparam int HDR_LEN = 3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HDR    = 3'd1,
    ST_BLANK  = 3'd2,
    ST_SDP    = 3'd3,
    ST_ACTIVE = 3'd4,
    ST_STUFF  = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    SYM_DATA, SYM_BS, SYM_BE, SYM_FS, SYM_FE, SYM_SS, SYM_SE, SYM_KOTH
  } sym_t;

  // Illegal lane_count falls back to single-lane decode.
  function automatic logic [3:0] lane_mask(input logic [1:0] lc);
    case (lc)
      LC_2:    lane_mask = 4'b0011;
      LC_4:    lane_mask = 4'b1111;
      default: lane_mask = 4'b0001;
    endcase
  endfunction

endpackage

// File: rtl/iso_rx_deframer_if.sv
// De-skewed main-link symbol bus from the lane aligner into the deframer.
interface iso_rx_deframer_if #(
  parameter int SYM_W     = 8,
  parameter int MAX_LANES = 4
);
  logic [MAX_LANES-1:0][SYM_W-1:0] ln_sym;
  logic [MAX_LANES-1:0]            ln_k;
  logic                            ln_vld;

  modport master (output ln_sym, ln_k, ln_vld);
  modport slave  (input  ln_sym, ln_k, ln_vld);
endinterface

// File: rtl/iso_rx_deframer_sym_classify.sv
// Combinational decode of the lane-0 symbol type, plus active-lane mask and
// cross-lane consistency check against lane 0.
module iso_rx_sym_classify
  import iso_rx_pkg::*;
#(
  parameter int SYM_W     = 8,
  parameter int MAX_LANES = 4
) (
  input  logic [MAX_LANES-1:0][SYM_W-1:0] sym_i,
  input  logic [MAX_LANES-1:0]            k_i,
  input  logic [1:0]                      lane_count_i,
  output sym_t                            sym_type_o,
  output logic [MAX_LANES-1:0]            act_mask_o,
  output logic                            lane_mis_o
);

  logic [MAX_LANES-1:0] mis;

  always_comb begin
    sym_type_o = SYM_DATA;
    if (k_i[0]) begin
      case (sym_i[0])
        K_BS, K_SR: sym_type_o = SYM_BS;
        K_BE:       sym_type_o = SYM_BE;
        K_FS:       sym_type_o = SYM_FS;
        K_FE:       sym_type_o = SYM_FE;
        K_SS:       sym_type_o = SYM_SS;
        K_SE:       sym_type_o = SYM_SE;
        default:    sym_type_o = SYM_KOTH;
      endcase
    end
  end

  assign act_mask_o = MAX_LANES'(lane_mask(lane_count_i));

  assign mis[0] = 1'b0;
  for (genvar i = 1; i < MAX_LANES; i++) begin : g_lane
    assign mis[i] = act_mask_o[i] &
                    ((k_i[i] != k_i[0]) |
                     (k_i[i] & k_i[0] & (sym_i[i] != sym_i[0])));
  end

  assign lane_mis_o = |mis;

endmodule

// File: rtl/iso_rx_deframer.sv
// DisplayPort main-link deframer: strips BS/header/BE/stuffing/SDP framing
// and emits active pixel bytes, timing pulses, VB-ID and per-line counts.
module iso_rx_deframer
  import iso_rx_pkg::*;
#(
  parameter int SYM_W     = 8,
  parameter int MAX_LANES = 4,
  parameter int CNT_W     = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            rx_en_i,
  input  logic [1:0]                      lane_count_i,
  iso_rx_deframer_if.slave                ln,
  output logic [MAX_LANES-1:0][SYM_W-1:0] rx_pix_data_o,
  output logic [MAX_LANES-1:0]            rx_pix_vld_o,
  output logic                            rx_bs_pulse_o,
  output logic                            rx_be_pulse_o,
  output logic                            rx_vblank_o,
  output logic                            rx_field_o,
  output logic                            rx_no_video_o,
  output logic [7:0]                      rx_mvid_o,
  output logic [CNT_W-1:0]                rx_sym_cnt_o,
  output logic [2:0]                      rx_state_o,
  output logic                            rx_frame_err_o,
  output logic                            rx_lane_err_o,
  output logic                            rx_cfg_err_o
);

  localparam int IDX_W = $clog2(HDR_LEN);

  sym_t                 sym_type;
  logic [MAX_LANES-1:0] act_mask;
  logic                 lane_mis;

  iso_rx_sym_classify #(.SYM_W(SYM_W), .MAX_LANES(MAX_LANES)) u_cls (
    .sym_i        (ln.ln_sym),
    .k_i          (ln.ln_k),
    .lane_count_i (lane_count_i),
    .sym_type_o   (sym_type),
    .act_mask_o   (act_mask),
    .lane_mis_o   (lane_mis)
  );

  state_t                          state_q, state_d;
  logic [IDX_W-1:0]                idx_q, idx_d;
  logic [CNT_W-1:0]                cnt_q, cnt_d;
  logic [MAX_LANES-1:0][SYM_W-1:0] pix_data_q, pix_data_d;
  logic [MAX_LANES-1:0]            pix_vld_q, pix_vld_d;
  logic                            bs_q, bs_d, be_q, be_d;
  logic                            vblank_q, vblank_d, field_q, field_d, nov_q, nov_d;
  logic [7:0]                      mvid_q, mvid_d;
  logic [CNT_W-1:0]                sym_cnt_q, sym_cnt_d;
  logic                            ferr_q, ferr_d, lerr_q, lerr_d, cerr_q, cerr_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      cnt_q      <= '0;
      pix_data_q <= '0;
      pix_vld_q  <= '0;
      bs_q       <= 1'b0;
      be_q       <= 1'b0;
      vblank_q   <= 1'b0;
      field_q    <= 1'b0;
      nov_q      <= 1'b0;
      mvid_q     <= '0;
      sym_cnt_q  <= '0;
      ferr_q     <= 1'b0;
      lerr_q     <= 1'b0;
      cerr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      pix_data_q <= pix_data_d;
      pix_vld_q  <= pix_vld_d;
      bs_q       <= bs_d;
      be_q       <= be_d;
      vblank_q   <= vblank_d;
      field_q    <= field_d;
      nov_q      <= nov_d;
      mvid_q     <= mvid_d;
      sym_cnt_q  <= sym_cnt_d;
      ferr_q     <= ferr_d;
      lerr_q     <= lerr_d;
      cerr_q     <= cerr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    pix_data_d = '0;
    pix_vld_d  = '0;
    bs_d       = 1'b0;
    be_d       = 1'b0;
    vblank_d   = vblank_q;
    field_d    = field_q;
    nov_d      = nov_q;
    mvid_d     = mvid_q;
    sym_cnt_d  = sym_cnt_q;
    ferr_d     = ferr_q;
    lerr_d     = lerr_q;
    cerr_d     = cerr_q;

    if (!rx_en_i) begin
      state_d = ST_IDLE;
      idx_d   = '0;
      ferr_d  = 1'b0;
      lerr_d  = 1'b0;
      cerr_d  = 1'b0;
    end else begin
      if (lane_count_i == LC_ILL) cerr_d = 1'b1;
      if (ln.ln_vld) begin
        if (lane_mis) lerr_d = 1'b1;
        // Every BS/SR on lane 0 marks a line boundary, whatever it triggers.
        if (sym_type == SYM_BS) bs_d = 1'b1;

        case (state_q)
          ST_IDLE: begin
            if (sym_type == SYM_BS) begin
              state_d = ST_HDR;
              idx_d   = '0;
            end
          end

          ST_HDR: begin
            if (sym_type != SYM_DATA) begin
              ferr_d  = 1'b1;
              state_d = ST_IDLE;
            end else begin
              if (idx_q == '0) begin
                vblank_d = ln.ln_sym[0][0];
                field_d  = ln.ln_sym[0][1];
                nov_d    = ln.ln_sym[0][3];
              end
              if (idx_q == IDX_W'(1)) mvid_d = ln.ln_sym[0][7:0];
              if (idx_q == IDX_W'(HDR_LEN-1)) begin
                state_d = ST_BLANK;
                idx_d   = '0;
              end else begin
                idx_d = idx_q + 1'b1;
              end
            end
          end

          ST_BLANK: begin
            case (sym_type)
              SYM_SS: state_d = ST_SDP;
              SYM_BS: begin
                state_d = ST_HDR;
                idx_d   = '0;
              end
              SYM_BE: begin
                if (vblank_q) begin
                  ferr_d = 1'b1;
                end else begin
                  state_d = ST_ACTIVE;
                  be_d    = 1'b1;
                  cnt_d   = '0;
                end
              end
              default: ;
            endcase
          end

          ST_SDP: begin
            if (sym_type == SYM_SE) begin
              state_d = ST_BLANK;
            end else if (sym_type == SYM_BS) begin
              ferr_d  = 1'b1;
              state_d = ST_HDR;
              idx_d   = '0;
            end
          end

          ST_ACTIVE, ST_STUFF: begin
            if (sym_type == SYM_BS) begin
              sym_cnt_d = cnt_q;
              state_d   = ST_HDR;
              idx_d     = '0;
            end else if (sym_type == SYM_DATA) begin
              // Stuffing symbols between FS and FE are dummies.
              if (state_q == ST_ACTIVE) begin
                pix_vld_d = act_mask;
                for (int i = 0; i < MAX_LANES; i++)
                  pix_data_d[i] = act_mask[i] ? ln.ln_sym[i] : '0;
                cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
              end
            end else if (state_q == ST_ACTIVE && sym_type == SYM_FS) begin
              state_d = ST_STUFF;
            end else if (state_q == ST_STUFF && sym_type == SYM_FE) begin
              state_d = ST_ACTIVE;
            end else begin
              ferr_d  = 1'b1;
              state_d = ST_IDLE;
            end
          end

          default: state_d = ST_IDLE;
        endcase
      end
    end
  end

  assign rx_pix_data_o  = pix_data_q;
  assign rx_pix_vld_o   = pix_vld_q;
  assign rx_bs_pulse_o  = bs_q;
  assign rx_be_pulse_o  = be_q;
  assign rx_vblank_o    = vblank_q;
  assign rx_field_o     = field_q;
  assign rx_no_video_o  = nov_q;
  assign rx_mvid_o      = mvid_q;
  assign rx_sym_cnt_o   = sym_cnt_q;
  assign rx_state_o     = state_q;
  assign rx_frame_err_o = ferr_q;
  assign rx_lane_err_o  = lerr_q;
  assign rx_cfg_err_o   = cerr_q;

endmodule
